// File: rtl/ssd_display_driver_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment display driver:
//   - conversion FSM state encoding
//   - display geometry (DIGITS) and input value width (NUM_W)
//   - active-low segment patterns {g,f,e,d,c,b,a} for decimal digits
//   - seg_encode(): nibble -> segment pattern, non-decimal nibbles blank
// ---------------------------------------------------------------------------
package ssd_pkg;

    localparam int DIGITS = 4;
    localparam int NUM_W  = 13;
    localparam int BCD_W  = 4 * DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } conv_state_t;

    // Element [n] holds the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] pat;
        pat = SEG_BLANK;
        if (nib <= 4'd9) begin
            pat = SEG_TABLE[nib];
        end
        return pat;
    endfunction

endpackage

// File: rtl/ssd_display_driver_if.sv
// ---------------------------------------------------------------------------
// ssd_display_driver_if
// Debug display bus between the CPU side and the display driver.
//   num      : binary value to show (CPU -> driver)
//   anode    : active-low digit enables (driver -> pins)
//   seg      : active-low segments {g,f,e,d,c,b,a} (driver -> pins)
//   busy     : conversion in progress (driver -> CPU side)
//   disp_val : value currently on the display (driver -> CPU side)
// master = value producer, slave = display driver.
// ---------------------------------------------------------------------------
interface ssd_display_driver_if;
    import ssd_pkg::*;

    logic [NUM_W-1:0] num;
    logic [3:0]       anode;
    logic [6:0]       seg;
    logic             busy;
    logic [NUM_W-1:0] disp_val;

    modport master (
        output num,
        input  anode,
        input  seg,
        input  busy,
        input  disp_val
    );

    modport slave (
        input  num,
        output anode,
        output seg,
        output busy,
        output disp_val
    );

endinterface

// File: rtl/ssd_display_driver_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one input bit per clock.
//   clk, rst : clock, synchronous active-high reset (control only)
//   start    : request a conversion of bin_in (accepted in IDLE)
//   bin_in   : binary value, captured in LOAD
//   busy     : registered, high from LOAD through COMMIT
//   done     : high during COMMIT; bcd_out/bin_out are valid then
//   bcd_out  : packed BCD result, digit 0 in bits [3:0]
//   bin_out  : the binary value that produced bcd_out
// Timing: start seen in IDLE at cycle N -> LOAD N+1, SHIFT N+2..N+14,
// COMMIT N+15.
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out,
    output logic [NUM_W-1:0] bin_out
);

    localparam logic [3:0] LAST_BIT = 4'(NUM_W - 1);

    conv_state_t      state;
    logic [3:0]       bit_cnt;
    logic [NUM_W-1:0] shift_bin;
    logic [NUM_W-1:0] cap_bin;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_adj;

    // Add 3 to each nibble >= 5 so the following shift carries correctly.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        acc_adj = dabble_adjust(acc);
    end

    always_ff @(posedge clk) begin
        // Datapath registers carry no reset; they are only read after LOAD.
        case (state)
            LOAD: begin
                shift_bin <= bin_in;
                cap_bin   <= bin_in;
                acc       <= '0;
            end
            SHIFT: begin
                acc       <= {acc_adj[BCD_W-2:0], shift_bin[NUM_W-1]};
                shift_bin <= {shift_bin[NUM_W-2:0], 1'b0};
            end
            default: ;
        endcase

        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    bit_cnt <= LAST_BIT;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt - 4'd1;
                    if (bit_cnt == 4'd0) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign done    = (state == COMMIT);
    assign bcd_out = acc;
    assign bin_out = cap_bin;

endmodule

// File: rtl/ssd_display_driver.sv
// ---------------------------------------------------------------------------
// ssd_display_driver
// Shows a 13-bit binary value on a 4-digit common-anode seven-segment
// display. A change of bus.num starts a sequential BCD conversion; only the
// committed result is ever displayed. Digits are scanned continuously, one
// slot of REFRESH_DIV clocks per digit.
// Parameters:
//   REFRESH_DIV : clocks per digit slot (>= 2)
//   BLANK_LZ    : 1 blanks leading zero digits (digit 0 always shown)
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : num in; anode, seg, busy, disp_val out (all registered)
// ---------------------------------------------------------------------------
module ssd_display_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
)
(
    input  logic                 clk,
    input  logic                 rst,
    ssd_display_driver_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]  ref_cnt;
    logic [1:0]        digit_idx;
    logic [BCD_W-1:0]  bcd_disp;
    logic [NUM_W-1:0]  disp_val_q;
    logic [3:0]        anode_q;
    logic [6:0]        seg_q;

    logic              conv_start;
    logic              conv_busy;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    logic [NUM_W-1:0]  conv_bin;

    logic [3:0]        cur_nib;
    logic [DIGITS-1:0] lz_mask;
    logic              cur_blank;

    // Bit k set when digit k and every digit above it are zero (k >= 1).
    function automatic logic [DIGITS-1:0] leading_zero_mask(input logic [BCD_W-1:0] bcd);
        logic [DIGITS-1:0] m;
        logic              run;
        m   = '0;
        run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run  = run && (bcd[4*k +: 4] == 4'd0);
            m[k] = run;
        end
        return m;
    endfunction

    // Comparing against the committed value means a change that arrives
    // mid-conversion is picked up on the next IDLE cycle.
    assign conv_start = (bus.num != disp_val_q);

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .start   (conv_start),
        .bin_in  (bus.num),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd),
        .bin_out (conv_bin)
    );

    always_comb begin
        cur_nib   = bcd_disp[{digit_idx, 2'b00} +: 4];
        lz_mask   = BLANK_LZ ? leading_zero_mask(bcd_disp) : '0;
        cur_blank = lz_mask[digit_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt    <= '0;
            digit_idx  <= '0;
            anode_q    <= 4'b1111;
            seg_q      <= SEG_BLANK;
            bcd_disp   <= '0;
            disp_val_q <= '0;
        end else begin
            if (ref_cnt == CNT_LAST) begin
                ref_cnt   <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + CNT_W'(1);
            end

            // anode and seg come from the same digit_idx, so they stay aligned.
            anode_q <= ~(4'b0001 << digit_idx);
            seg_q   <= cur_blank ? SEG_BLANK : seg_encode(cur_nib);

            if (conv_done) begin
                bcd_disp   <= conv_bcd;
                disp_val_q <= conv_bin;
            end
        end
    end

    assign bus.anode    = anode_q;
    assign bus.seg      = seg_q;
    assign bus.busy     = conv_busy;
    assign bus.disp_val = disp_val_q;

endmodule
